transmitter: RTL
================

# transmitter

UART serial transmitter that serialises one parallel byte per request into a standard 8N1-style frame (start bit, LSB-first data, stop bit(s)) on `tx`. It sits directly upstream of the UART receiver: its `tx` output drives the receiver's `rx` input, and both share the same 16x-oversampled baud `tick`. The frame timing therefore matches the receiver's 16-tick bit period exactly.

## Interface
- `DATA_WIDTH`, 8: data bits per frame.
- `STOP_BITS`, 1: number of stop bits; only 1 or 2 are legal.
- `clk` input 1: single clock; all logic on the rising edge.
- `arst_n` input 1: reset, synchronous and active-low.
- `tick` input 1: one-cycle baud pulse at 16x the bit rate, from the shared baud generator.
- `tx_start` input 1: request to send `data_in`; sampled only in IDLE.
- `data_in` input DATA_WIDTH: byte to send; latched on acceptance.
- `tx` output 1: serial line, idle high.
- `tx_busy` output 1: high while a frame is in progress (state != IDLE).
- `tx_done` output 1: one-cycle pulse at frame end.

## Operation
- States: IDLE, START, DATA, STOP.
- IDLE:
  - `tx`=1.
  - On `tx_start`=1, latch `data_in` into the shift register, clear the tick and bit counters, and go to START.
- START:
  - `tx`=0.
  - Count ticks 0..15; on the tick that arrives with count==15, clear the count and go to DATA.
- DATA:
  - `tx`=shift_reg[0].
  - On the tick with count==15, shift right by one, clear the count, and increment the bit counter.
  - After bit DATA_WIDTH-1, go to STOP.
- STOP:
  - `tx`=1.
  - Each stop bit lasts 16 ticks.
  - After STOP_BITS×16 ticks, go to IDLE and pulse `tx_done`.
- Counters:
  - Tick counter is 4 bits and wraps naturally at 15.
  - Bit counter is $clog2(DATA_WIDTH)+1 bits wide.
  - Stop-bit counter is 1 bit.
- `tx_start` is ignored while not in IDLE; `data_in` is don't-care after acceptance.
- `tick` outside START/DATA/STOP has no effect.

## Timing
- Reset values: `tx`=1, `tx_busy`=0, `tx_done`=0, state=IDLE, all counters and the shift register 0.
- All outputs are registered; no combinational path from inputs to outputs.
- Acceptance latency:
  - `tx_start` is sampled high at edge N.
  - At N+1: `tx`=0 and `tx_busy`=1.
- Frame length: (1 + DATA_WIDTH + STOP_BITS)×16 ticks, counted from the first tick after acceptance.
- End of frame, on the edge that consumes the final stop tick:
  - state becomes IDLE; `tx_busy`=0 and `tx_done`=1 for exactly one cycle.
  - `tx` stays 1.
- Back-to-back: `tx_start` high during the `tx_done` cycle is accepted, and the next start bit begins on the following edge with zero idle gap.
- Simultaneous `tx_start` and `tick` in IDLE: the tick is not counted; counting starts with the next tick.
- Reset mid-frame: the next edge with `arst_n`=0 forces IDLE and `tx`=1 with no `tx_done`.
  - The partial frame is abandoned; the receiver sees a truncated frame, which is acceptable.

## Structure
- Shared package `uart_pkg`:
  - `tx_state_t` enum (IDLE, START, DATA, STOP).
  - `OVERSAMPLE` = 16.
  - `BIT_SAMPLING` = 15.
  - The receiver and future UART blocks share these.
- Single module, no sub-modules; the baud tick generator is instantiated at the top level, not inside this block.
- Two-process style: registered state/datapath plus a combinational next-state block, with all next-values defaulted to current values.

## Test plan
- Byte 0x55, `tick` every cycle, STOP_BITS=1 → `tx` pattern 0,1,0,1,0,1,0,1,0,1, each level held 16 cycles; `tx_done` pulses 160 cycles after the start edge.
- Loopback: `tx` wired to the receiver `rx`; send 0xA3, 0x00, 0xFF with `tick` every 4 cycles → receiver `data_out` matches each byte and one `rx_done` fires per frame.
- Back-to-back: 0x12 then 0x34, with `tx_start` held in the `tx_done` cycle → no idle high between the stop bit and the next start bit; both bytes decoded correctly.
- `tx_start` pulsed with 0xEE during DATA of frame 0x0F → frame 0x0F is unchanged, 0xEE is never sent, and `tx_busy` is continuously high.
- Reset asserted mid-DATA → next edge gives `tx`=1, `tx_busy`=0, `tx_done`=0; a subsequent 0x81 transmits correctly.
- STOP_BITS=2, byte 0xC6 → stop high lasts 32 ticks; total frame is 176 ticks.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and oversampling constants
// used by the transmitter, the receiver and later UART blocks.
package uart_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } tx_state_t;

  localparam int unsigned OVERSAMPLE   = 16;
  localparam int unsigned BIT_SAMPLING = 15;

endpackage

// File: rtl/transmitter.sv
// UART transmitter: serialises one byte per request into start, LSB-first data and
// stop bits on tx, each bit lasting 16 baud ticks. STOP_BITS must be 1 or 2.
module transmitter
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  tick,
  input  logic                  tx_start,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  tx,
  output logic                  tx_busy,
  output logic                  tx_done
);

  localparam int unsigned BitCntW = $clog2(DATA_WIDTH) + 1;

  localparam logic [3:0]         TickLast = 4'(BIT_SAMPLING);
  localparam logic [BitCntW-1:0] BitLast  = BitCntW'(DATA_WIDTH - 1);
  localparam logic               StopLast = 1'(STOP_BITS - 1);

  tx_state_t             state_q, state_d;
  logic [3:0]            tick_cnt_q, tick_cnt_d;
  logic [BitCntW-1:0]    bit_cnt_q, bit_cnt_d;
  logic                  stop_cnt_q, stop_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    shift_d    = shift_q;
    done_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        // A tick arriving with the request is deliberately not counted.
        if (tx_start) begin
          shift_d    = data_in;
          tick_cnt_d = '0;
          bit_cnt_d  = '0;
          stop_cnt_d = 1'b0;
          state_d    = StStart;
        end
      end
      StStart: begin
        if (tick) begin
          tick_cnt_d = tick_cnt_q + 4'd1;
          if (tick_cnt_q == TickLast) begin
            state_d = StData;
          end
        end
      end
      StData: begin
        if (tick) begin
          tick_cnt_d = tick_cnt_q + 4'd1;
          if (tick_cnt_q == TickLast) begin
            shift_d = shift_q >> 1;
            if (bit_cnt_q == BitLast) begin
              bit_cnt_d = '0;
              state_d   = StStop;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
        end
      end
      StStop: begin
        if (tick) begin
          tick_cnt_d = tick_cnt_q + 4'd1;
          if (tick_cnt_q == TickLast) begin
            if (stop_cnt_q == StopLast) begin
              stop_cnt_d = 1'b0;
              done_d     = 1'b1;
              state_d    = StIdle;
            end else begin
              stop_cnt_d = stop_cnt_q + 1'b1;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Line level follows the next state so tx changes on the same edge as the state.
  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state_d != StIdle);
    unique case (state_d)
      StIdle:  tx_d = 1'b1;
      StStart: tx_d = 1'b0;
      StData:  tx_d = shift_d[0];
      StStop:  tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state_q    <= StIdle;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign tx      = tx_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;

endmodule
